doa_frame_sequencer: RTL

- Per-frame controller for the direction-of-arrival (DOA) pipeline.
- On each FFT-done pulse it starts the frequency-detect stage, then the weighting stage, then commits the resulting DOA/beam number to stable output registers.
- Owns the single read port of FFT RAM 1, which the detect and weighting stages share, and muxes it to the active stage.
- Guards against overlapping frames (overrun) and hung stages (timeout).

---
 rtl/doa_frame_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/doa_frame_sequencer.sv
// Per-frame DOA pipeline controller: sequences detect -> weight -> commit and owns the RAM 1 read port.
// Optional macro DOA_SMOOTH_EN averages each committed DOA with the previous one.
module doa_frame_sequencer #(
    parameter int ADDR_W  = 10,
    parameter int DOA_W   = 8,
    parameter int BNUM_W  = 6,
    parameter int TIMEOUT = 16384,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic [3:0]        KEY,
    input  logic              fftdone,
    output logic              detect_start,
    input  logic              detectdone,
    output logic              weight_start,
    input  logic              wdone,
    input  logic [DOA_W-1:0]  wdoa,
    input  logic [BNUM_W-1:0] wbnum,
    input  logic [ADDR_W-1:0] det_addr,
    input  logic [ADDR_W-1:0] wgt_addr,
    output logic [ADDR_W-1:0] ram1_addr,
    output logic [DOA_W-1:0]  doa,
    output logic [BNUM_W-1:0] bnum,
    output logic              valid,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              overrun,
    output logic              timeout_err,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        WEIGHT = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t          cur;
    logic            rst_n;
    logic            unused_keys;
    logic            pending;
    logic [WD_W-1:0] wdog;
    logic            wd_expired;
    logic [DOA_W-1:0] doa_next;

    assign rst_n       = KEY[0];
    assign unused_keys = ^KEY[3:1];
    assign state       = cur;
    // Expiry fires on the TIMEOUT-th cycle spent in the stage; a done pulse that same cycle takes priority.
    assign wd_expired  = (wdog == WD_W'(TIMEOUT - 1));

`ifdef DOA_SMOOTH_EN
    logic             first_frame;
    logic [DOA_W:0]   doa_sum;

    assign doa_sum  = {1'b0, doa} + {1'b0, wdoa} + {{DOA_W{1'b0}}, 1'b1};
    assign doa_next = first_frame ? wdoa : doa_sum[DOA_W:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            first_frame <= 1'b1;
        else if (cur == WEIGHT && wdone)
            first_frame <= 1'b0;
    end
`else
    assign doa_next = wdoa;
`endif

    always_comb begin
        ram1_addr = '0;
        case (cur)
            DETECT:  ram1_addr = det_addr;
            WEIGHT:  ram1_addr = wgt_addr;
            default: ram1_addr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= IDLE;
            detect_start <= 1'b0;
            weight_start <= 1'b0;
            valid        <= 1'b0;
            doa          <= '0;
            bnum         <= '0;
            frame_cnt    <= '0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
            pending      <= 1'b0;
            wdog         <= '0;
        end else begin
            detect_start <= 1'b0;
            weight_start <= 1'b0;
            valid        <= 1'b0;

            // One-deep frame buffer while busy; a second arrival is dropped.
            if (fftdone && cur != IDLE) begin
                if (pending)
                    overrun <= 1'b1;
                else
                    pending <= 1'b1;
            end

            case (cur)
                IDLE: begin
                    if (fftdone || pending) begin
                        cur          <= DETECT;
                        detect_start <= 1'b1;
                        wdog         <= '0;
                        pending      <= pending & fftdone;
                    end
                end
                DETECT: begin
                    if (detectdone) begin
                        cur          <= WEIGHT;
                        weight_start <= 1'b1;
                        wdog         <= '0;
                    end else if (wd_expired) begin
                        cur         <= IDLE;
                        timeout_err <= 1'b1;
                        wdog        <= '0;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                WEIGHT: begin
                    if (wdone) begin
                        cur       <= COMMIT;
                        doa       <= doa_next;
                        bnum      <= wbnum;
                        valid     <= 1'b1;
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        wdog      <= '0;
                    end else if (wd_expired) begin
                        cur         <= IDLE;
                        timeout_err <= 1'b1;
                        wdog        <= '0;
                    end else begin
                        wdog <= wdog + WD_W'(1);
                    end
                end
                COMMIT:  cur <= IDLE;
                default: cur <= IDLE;
            endcase
        end
    end

endmodule
